// File: rtl/fb_bank_arbiter_if.sv
// fb_bank_arbiter_if
//   Bundles the signals between the framebuffer bank arbiter, its two
//   requesters (scan-side pixel loader, host write path) and the
//   single-port framebuffer RAM.
//   Modports:
//     slave  - arbiter view: takes requests and mem_rdata, drives the
//              handshakes, bank status and the RAM strobe/address/data.
//     master - requester/RAM view: the mirror image.
//   Clock and reset are not part of the bundle; they stay plain ports.
interface fb_bank_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  // scan read side
  logic                  scan_req;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  scan_ready;
  logic [DATA_WIDTH-1:0] scan_rdata;
  logic                  scan_rvalid;
  // host write side
  logic                  host_wr_valid;
  logic [ADDR_WIDTH-1:0] host_wr_addr;
  logic [DATA_WIDTH-1:0] host_wr_data;
  logic                  host_wr_ready;
  // bank swap control
  logic                  swap_req;
  logic                  frame_end;
  logic                  swap_pending;
  logic                  display_bank;
  // framebuffer RAM
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH:0]   mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  scan_req, scan_addr, host_wr_valid, host_wr_addr, host_wr_data,
           swap_req, frame_end, mem_rdata,
    output scan_ready, scan_rdata, scan_rvalid, host_wr_ready,
           swap_pending, display_bank, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output scan_req, scan_addr, host_wr_valid, host_wr_addr, host_wr_data,
           swap_req, frame_end, mem_rdata,
    input  scan_ready, scan_rdata, scan_rvalid, host_wr_ready,
           swap_pending, display_bank, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_bank_arbiter.sv
// fb_bank_arbiter
//   Sequences all access to the single-port, double-buffered framebuffer
//   RAM. Scan reads always go to the display bank, host writes always go
//   to the back bank. Scan wins conflicts unless the host has been refused
//   STARVE_LIMIT cycles in a row, in which case one host write is forced
//   through. Bank swaps are requested by swap_req and take effect on the
//   next frame_end pulse.
//   Ports:
//     clk_in - system clock, rising edge
//     reset  - synchronous, active-low reset
//     bus    - fb_bank_arbiter_if.slave (scan, host, swap and RAM signals)
module fb_bank_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  fb_bank_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  swap_state_e           swap_state_q, swap_state_d;
  logic                  display_bank_q, display_bank_d;
  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd_pipe_q, rd_pipe_d;
  logic                  scan_rvalid_q, scan_rvalid_d;

  logic forced;
  logic scan_ready;
  logic host_wr_ready;
  logic scan_acc;
  logic host_acc;

  // Arbitration. Both readys are held low during reset so nothing is
  // accepted while the block is being cleared.
  always_comb begin
    forced        = bus.host_wr_valid && (starve_cnt_q == LIMIT);
    scan_ready    = reset && !forced;
    host_wr_ready = reset && bus.host_wr_valid && (!bus.scan_req || forced);
    scan_acc      = bus.scan_req && scan_ready;
    host_acc      = bus.host_wr_valid && host_wr_ready;
  end

  // Next-state logic: swap FSM, starve counter, RAM drive, read-valid pipe.
  always_comb begin
    swap_state_d   = swap_state_q;
    display_bank_d = display_bank_q;
    starve_cnt_d   = starve_cnt_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rd_pipe_d      = scan_acc;
    scan_rvalid_d  = rd_pipe_q;

    // A swap_req arriving together with frame_end only arms the swap; the
    // toggle waits for a later frame_end. swap_req while pending is dropped.
    case (swap_state_q)
      SWAP_IDLE: begin
        if (bus.swap_req) swap_state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (bus.frame_end) begin
          swap_state_d   = SWAP_IDLE;
          display_bank_d = ~display_bank_q;
        end
      end
      default: swap_state_d = SWAP_IDLE;
    endcase

    if (!bus.host_wr_valid || host_acc) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    // The bank bit is taken from the current (pre-swap) display bank, so an
    // access accepted on the swap edge still uses the old bank assignment.
    if (scan_acc) begin
      mem_en_d   = 1'b1;
      mem_addr_d = {display_bank_q, bus.scan_addr};
    end else if (host_acc) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = {~display_bank_q, bus.host_wr_addr};
      mem_wdata_d = bus.host_wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      swap_state_q   <= SWAP_IDLE;
      display_bank_q <= 1'b0;
      starve_cnt_q   <= 8'd0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rd_pipe_q      <= 1'b0;
      scan_rvalid_q  <= 1'b0;
    end else begin
      swap_state_q   <= swap_state_d;
      display_bank_q <= display_bank_d;
      starve_cnt_q   <= starve_cnt_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rd_pipe_q      <= rd_pipe_d;
      scan_rvalid_q  <= scan_rvalid_d;
    end
  end

  assign bus.scan_ready    = scan_ready;
  assign bus.host_wr_ready = host_wr_ready;
  assign bus.scan_rdata    = bus.mem_rdata;
  assign bus.scan_rvalid   = scan_rvalid_q;
  assign bus.swap_pending  = (swap_state_q == SWAP_PENDING);
  assign bus.display_bank  = display_bank_q;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;

endmodule
